// File: rtl/fetch_stage.sv
// Purpose: byte-serial instruction fetch from a loadable byte memory into little-endian words.
// Latency: first word valid 5 cycles after start, next word 4 cycles after each accepted word.
// Backpressure: a finished word is held on instr/pc until instr_ready; redirect discards it.
module fetch_stage #(
    parameter int MAX_LINES  = 128,
    parameter int INSTR_SIZE = 32,
    parameter int BYTE_SIZE  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_en,
    input  logic [6:0]            load_addr,
    input  logic [BYTE_SIZE-1:0]  load_data,
    input  logic                  start,
    input  logic                  redirect_valid,
    input  logic [6:0]            redirect_pc,
    input  logic                  instr_ready,
    output logic                  instr_valid,
    output logic [INSTR_SIZE-1:0] instr,
    output logic [6:0]            pc,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEN   = 3'd1,
        FETCH = 3'd2,
        HOLD  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int LANES = INSTR_SIZE / BYTE_SIZE;

    logic [BYTE_SIZE-1:0]  mem [0:MAX_LINES-1];

    state_t                state, state_nxt;
    logic [6:0]            pc_nxt;
    logic [1:0]            cnt, cnt_nxt;
    logic [7:0]            len, len_nxt;
    logic [INSTR_SIZE-1:0] instr_nxt;

    // Read address and sums are kept 8 bits wide so pc+cnt and pc+3 never wrap.
    logic [7:0]            rd_addr;
    logic [BYTE_SIZE-1:0]  rd_byte;
    logic [7:0]            pc_inc;
    logic [7:0]            redir_end;
    logic [7:0]            inc_end;

    assign rd_addr   = {1'b0, pc} + {6'b0, cnt};
    assign rd_byte   = (32'(rd_addr) < MAX_LINES) ? mem[rd_addr[6:0]] : '0;
    assign pc_inc    = {1'b0, pc} + 8'd4;
    assign inc_end   = pc_inc + 8'd3;
    assign redir_end = {1'b0, redirect_pc} + 8'd3;

    assign instr_valid = (state == HOLD);
    assign busy        = (state == LEN) || (state == FETCH) || (state == HOLD);
    assign done        = (state == DONE);

    // Program memory: no reset, writes only accepted while the fetcher is parked.
    always_ff @(posedge clk) begin
        if (load_en && (state == IDLE || state == DONE) && (32'(load_addr) < MAX_LINES)) begin
            mem[load_addr] <= load_data;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            pc    <= '0;
            cnt   <= '0;
            len   <= '0;
            instr <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            cnt   <= cnt_nxt;
            len   <= len_nxt;
            instr <= instr_nxt;
        end
    end

    // Next-state logic; redirect beats a same-cycle handshake so the held word is not consumed.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        cnt_nxt   = cnt;
        len_nxt   = len;
        instr_nxt = instr;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = LEN;
                end
            end
            LEN: begin
                len_nxt   = mem[0];
                pc_nxt    = 7'd1;
                cnt_nxt   = 2'd0;
                state_nxt = (8'd4 < mem[0]) ? FETCH : DONE;
            end
            FETCH: begin
                if (redirect_valid) begin
                    pc_nxt    = redirect_pc;
                    cnt_nxt   = 2'd0;
                    state_nxt = (redir_end < len) ? FETCH : DONE;
                end else begin
                    for (int i = 0; i < LANES; i++) begin
                        if (cnt == i[1:0]) begin
                            instr_nxt[i*BYTE_SIZE +: BYTE_SIZE] = rd_byte;
                        end
                    end
                    cnt_nxt = cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    pc_nxt    = redirect_pc;
                    cnt_nxt   = 2'd0;
                    state_nxt = (redir_end < len) ? FETCH : DONE;
                end else if (instr_ready) begin
                    pc_nxt    = pc_inc[6:0];
                    cnt_nxt   = 2'd0;
                    state_nxt = (inc_end < len) ? FETCH : DONE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        load_en;
    logic [6:0]  load_addr;
    logic [7:0]  load_data;
    logic        start;
    logic        redirect_valid;
    logic [6:0]  redirect_pc;
    logic        instr_ready;
    logic        instr_valid;
    logic [31:0] instr;
    logic [6:0]  pc;
    logic        busy;
    logic        done;

    int checks;
    int errors;

    fetch_stage #(
        .MAX_LINES (128),
        .INSTR_SIZE(32),
        .BYTE_SIZE (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .load_en       (load_en),
        .load_addr     (load_addr),
        .load_data     (load_data),
        .start         (start),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .instr_ready   (instr_ready),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .pc            (pc),
        .busy          (busy),
        .done          (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic load(input logic [6:0] a, input logic [7:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        tick();
        load_en   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    logic [7:0]  prog [0:8];
    logic [31:0] held_instr;
    logic [6:0]  held_pc;
    int          stuck;

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        load_en = 1'b0;
        load_addr = '0;
        load_data = '0;
        start = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b0;
        prog = '{8'd9, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};

        // Reset state
        #2;
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_busy",  32'(busy),        32'd0);
        chk("rst_done",  32'(done),        32'd0);
        chk("rst_pc",    32'(pc),          32'd0);
        chk("rst_instr", instr,            32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) load(7'(i), prog[i]);

        // Two-word program, latency and HOLD backpressure
        pulse_start();
        ticks(4);
        chk("lat_valid_k4", 32'(instr_valid), 32'd0);
        chk("lat_busy_k4",  32'(busy),        32'd1);
        tick();
        chk("w0_valid", 32'(instr_valid), 32'd1);
        chk("w0_instr", instr,            32'h0000_0013);
        chk("w0_pc",    32'(pc),          32'd1);
        held_instr = instr;
        held_pc    = pc;
        stuck = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!instr_valid || instr !== held_instr || pc !== held_pc) stuck++;
        end
        chk("hold_stable_cycles", 32'(stuck), 32'd0);
        chk("hold_instr", instr, 32'h0000_0013);
        chk("hold_pc",    32'(pc), 32'd1);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("hs_pc",    32'(pc),          32'd5);
        chk("hs_valid", 32'(instr_valid), 32'd0);
        ticks(3);
        chk("lat_valid_h3", 32'(instr_valid), 32'd0);
        tick();
        chk("w1_valid", 32'(instr_valid), 32'd1);
        chk("w1_instr", instr,            32'h0010_0093);
        chk("w1_pc",    32'(pc),          32'd5);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("end_done",  32'(done),        32'd1);
        chk("end_busy",  32'(busy),        32'd0);
        chk("end_valid", 32'(instr_valid), 32'd0);

        // Short program L=3 fetches nothing
        load(7'd0, 8'd3);
        pulse_start();
        chk("l3_len_busy",  32'(busy),        32'd1);
        chk("l3_len_valid", 32'(instr_valid), 32'd0);
        tick();
        chk("l3_done",  32'(done),        32'd1);
        chk("l3_valid", 32'(instr_valid), 32'd0);
        load(7'd0, 8'd9);

        // Redirect in FETCH cnt=2, with a dropped load while busy
        pulse_start();            // LEN
        tick();                   // FETCH cnt=0
        load(7'd1, 8'hFF);        // busy: dropped; now cnt=1
        tick();                   // cnt=2
        redirect_valid = 1'b1;
        redirect_pc    = 7'd5;
        tick();
        redirect_valid = 1'b0;
        chk("rf_pc",    32'(pc),          32'd5);
        chk("rf_valid", 32'(instr_valid), 32'd0);
        chk("rf_busy",  32'(busy),        32'd1);
        ticks(4);
        chk("rf_w_valid", 32'(instr_valid), 32'd1);
        chk("rf_w_instr", instr,            32'h0010_0093);
        chk("rf_w_pc",    32'(pc),          32'd5);

        // Redirect in HOLD beats ready: handshake would have ended the program
        redirect_valid = 1'b1;
        redirect_pc    = 7'd1;
        instr_ready    = 1'b1;
        tick();
        redirect_valid = 1'b0;
        instr_ready    = 1'b0;
        chk("rh_pc",    32'(pc),          32'd1);
        chk("rh_done",  32'(done),        32'd0);
        chk("rh_valid", 32'(instr_valid), 32'd0);
        ticks(4);
        chk("busy_load_dropped", instr, 32'h0000_0013);
        chk("rh_w_pc",           32'(pc), 32'd1);

        redirect_valid = 1'b1;
        redirect_pc    = 7'd5;
        instr_ready    = 1'b1;
        tick();
        redirect_valid = 1'b0;
        instr_ready    = 1'b0;
        chk("rh5_pc", 32'(pc), 32'd5);
        ticks(4);
        chk("rh5_instr", instr, 32'h0010_0093);
        chk("rh5_valid", 32'(instr_valid), 32'd1);

        // Redirect whose word would run past L goes to DONE
        redirect_valid = 1'b1;
        redirect_pc    = 7'd6;
        tick();
        redirect_valid = 1'b0;
        chk("rdone_done", 32'(done), 32'd1);
        chk("rdone_pc",   32'(pc),   32'd6);

        // Asynchronous reset in FETCH cnt=1
        pulse_start();            // LEN
        tick();                   // FETCH cnt=0
        tick();                   // FETCH cnt=1
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy",  32'(busy),        32'd0);
        chk("arst_done",  32'(done),        32'd0);
        chk("arst_valid", 32'(instr_valid), 32'd0);
        chk("arst_pc",    32'(pc),          32'd0);
        chk("arst_instr", instr,            32'd0);
        rst_n = 1'b1;
        stuck = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (instr_valid || busy) stuck++;
        end
        chk("post_rst_quiet", 32'(stuck), 32'd0);
        pulse_start();
        ticks(5);
        chk("rst_restart_valid", 32'(instr_valid), 32'd1);
        chk("rst_restart_pc",    32'(pc),          32'd1);
        chk("rst_restart_instr", instr,            32'h0000_0013);

        // Reads past the end of memory return zero
        redirect_valid = 1'b1;
        redirect_pc    = 7'd6;
        tick();
        redirect_valid = 1'b0;
        load(7'd0,   8'd255);
        load(7'd126, 8'hAA);
        load(7'd127, 8'hBB);
        pulse_start();            // LEN
        tick();                   // FETCH pc=1
        redirect_valid = 1'b1;
        redirect_pc    = 7'd126;
        tick();
        redirect_valid = 1'b0;
        ticks(4);
        chk("oob_valid", 32'(instr_valid), 32'd1);
        chk("oob_instr", instr,            32'h0000_BBAA);
        chk("oob_pc",    32'(pc),          32'd126);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter MAX_LINES, default 128, SHALL set the depth of the byte-wide instruction memory.
REQ-002 Parameter INSTR_SIZE, default 32, SHALL set the instruction word width.
REQ-003 Parameter BYTE_SIZE, default 8, SHALL set the memory byte width.
REQ-004 clk  input  1  SHALL be the sole clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 load_en  input  1  SHALL write load_data to mem[load_addr] at the clock edge.
REQ-007 load_addr  input  7  SHALL be the byte write address.
REQ-008 load_data  input  8  SHALL be the byte write data.
REQ-009 start  input  1  SHALL be a one-cycle request to begin fetching the program.
REQ-010 redirect_valid  input  1  SHALL request a PC change, e.g. a taken branch.
REQ-011 redirect_pc  input  7  SHALL be the new byte address of the next word.
REQ-012 instr_ready  input  1  SHALL indicate that decode accepts instr this cycle.
REQ-013 instr_valid  output  1  SHALL indicate that instr and pc hold a complete word.
REQ-014 instr  output  32  SHALL be the assembled instruction word.
REQ-015 pc  output  7  SHALL be the byte address of the word's lowest byte.
REQ-016 busy  output  1  SHALL be high in states LEN, FETCH and HOLD.
REQ-017 done  output  1  SHALL be high in state DONE.

Function
REQ-018 Memory layout SHALL be fixed: mem[0] holds program length L (unsigned, bytes), and instruction words start at byte address 1.
REQ-019 Words SHALL be little-endian: instr = {mem[a+3], mem[a+2], mem[a+1], mem[a]}.
REQ-020 The FSM SHALL have the states IDLE, LEN, FETCH, HOLD and DONE.
REQ-021 IDLE or DONE with start=1 SHALL go to LEN; start in any other state SHALL be ignored.
REQ-022 LEN SHALL latch L=mem[0], set pc=1, and go to FETCH if pc+3 < L, else go to DONE.
REQ-023 FETCH SHALL read one byte per cycle into byte lane cnt using a 2-bit counter cnt=0..3, and go to HOLD after the cnt=3 capture.
REQ-024 HOLD SHALL assert instr_valid and keep instr and pc stable until instr_ready=1.
REQ-025 A HOLD handshake SHALL set pc=pc+4 and go to FETCH if (new pc)+3 < L, else go to DONE.
REQ-026 The termination compare SHALL use 8-bit unsigned arithmetic so that pc+3 never wraps; L<4 SHALL fetch no words.
REQ-027 Read addresses at or above MAX_LINES SHALL return 0 and SHALL NOT stall the FSM.
REQ-028 Redirect in FETCH or HOLD SHALL discard any partial or held word, set pc=redirect_pc and cnt=0, and go to FETCH, or to DONE if redirect_pc+3 >= L.
REQ-029 Redirect SHALL have priority over a same-cycle handshake; that word SHALL be treated as not consumed.
REQ-030 Redirect in IDLE, LEN or DONE SHALL be ignored.
REQ-031 load_en SHALL take effect only in IDLE or DONE; writes while busy=1 SHALL be dropped.
REQ-032 Latency SHALL be: start sampled at edge k gives instr_valid high after edge k+5; a handshake at edge h gives the next instr_valid after edge h+4.
REQ-033 instr_valid SHALL be low in every state except HOLD.

Reset
REQ-034 rst_n=0 SHALL immediately force state=IDLE, pc=0, cnt=0, L=0, instr=0, instr_valid=0, busy=0 and done=0.
REQ-035 Reset SHALL NOT clear memory contents.
REQ-036 Reset asserted during FETCH or HOLD SHALL abort the operation; no word SHALL be presented after release until a new start.

Verification
REQ-037 Load mem[0]=9 and bytes 1..8 = 13 00 00 00 93 00 10 00, then start -> instr=0x00000013 at pc=1, then 0x00100093 at pc=5, then done=1.
REQ-038 Hold instr_ready=0 for 10 cycles in HOLD -> instr_valid stays 1 and instr/pc stay constant; one ready cycle advances pc by 4.
REQ-039 L=3, start -> DONE directly after LEN; instr_valid never asserts.
REQ-040 Redirect_pc=5 in FETCH cnt=2 and in HOLD together with instr_ready=1 -> next presented word is from pc=5; the dropped word is never accepted.
REQ-041 Drop rst_n in FETCH cnt=1 -> all outputs 0 asynchronously; after release and start, fetch restarts at pc=1.
REQ-042 load_en while busy -> memory unchanged, confirmed by a later fetch of the same address.
